// File: rtl/ahb_slave_mux_slave_3_if.sv
// Bus bundle between the masters that can reach slave 3, the slave-3 mux and slave 3 itself.
// The master modport is the mux's view; the slave modport is the surrounding environment's view.
interface ahb_slave_mux_slave_3_if #(
  parameter int unsigned SLAVE_X_MASTER_NUM = 2,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 32
);
  // Arbiter side
  logic [SLAVE_X_MASTER_NUM-1:0] hgrant;
  logic                          hsel_arb;
  logic                          hwait;
  logic [2:0]                    hburst;

  // Per-master request side
  logic [ADDR_WIDTH-1:0] haddr_m  [SLAVE_X_MASTER_NUM];
  logic [1:0]            htrans_m [SLAVE_X_MASTER_NUM];
  logic                  hwrite_m [SLAVE_X_MASTER_NUM];
  logic [2:0]            hsize_m  [SLAVE_X_MASTER_NUM];
  logic [2:0]            hburst_m [SLAVE_X_MASTER_NUM];
  logic [DATA_WIDTH-1:0] hwdata_m [SLAVE_X_MASTER_NUM];

  // Slave side
  logic [ADDR_WIDTH-1:0] haddr_s;
  logic [1:0]            htrans_s;
  logic                  hwrite_s;
  logic [2:0]            hsize_s;
  logic [2:0]            hburst_s;
  logic [DATA_WIDTH-1:0] hwdata_s;
  logic                  hsel_s;
  logic                  hreadyout_s;
  logic                  hresp_s;
  logic [DATA_WIDTH-1:0] hrdata_s;

  // Per-master response side
  logic [SLAVE_X_MASTER_NUM-1:0] hready_m;
  logic [SLAVE_X_MASTER_NUM-1:0] hresp_m;
  logic [DATA_WIDTH-1:0]         hrdata_m;

  modport master (
    input  hgrant, hsel_arb, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m, hwdata_m,
    input  hreadyout_s, hresp_s, hrdata_s,
    output haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hwdata_s, hsel_s,
    output hready_m, hresp_m, hrdata_m, hwait, hburst
  );

  modport slave (
    output hgrant, hsel_arb, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m, hwdata_m,
    output hreadyout_s, hresp_s, hrdata_s,
    input  haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hwdata_s, hsel_s,
    input  hready_m, hresp_m, hrdata_m, hwait, hburst
  );
endinterface

// File: rtl/ahb_slave_mux_slave_3.sv
// Slave-3 AHB mux: routes the granted master's address phase and the data-phase owner's write
// data to slave 3, and fans the slave response back out to the masters.
module ahb_slave_mux_slave_3 #(
  parameter int unsigned SLAVE_X_MASTER_NUM = 2,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 32
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  ahb_slave_mux_slave_3_if.master         bus_io
);
  localparam int unsigned N = SLAVE_X_MASTER_NUM;
  localparam logic [N-1:0] One = N'(1);

  logic [N-1:0]          addr_owner_q, addr_owner_d;
  logic [N-1:0]          data_owner_q, data_owner_d;
  logic [N-1:0]          grant_low, addr_sel;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [1:0]            a_trans;
  logic                  a_write;
  logic [2:0]            a_size;
  logic [2:0]            a_burst;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  err_first;
  logic [1:0]            htrans_out;
  logic                  hsel_out;
  logic [2:0]            hburst_out;

  // Isolate the lowest set grant bit so a malformed grant still yields a one-hot select.
  assign grant_low = bus_io.hgrant & (~bus_io.hgrant + One);
  assign addr_sel  = (|bus_io.hgrant) ? grant_low : addr_owner_q;
  assign err_first = bus_io.hresp_s & ~bus_io.hreadyout_s;

  always_comb begin
    a_addr  = '0;
    a_trans = 2'b00;
    a_write = 1'b0;
    a_size  = 3'b000;
    a_burst = 3'b000;
    d_wdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (addr_sel[i]) begin
        a_addr  = bus_io.haddr_m[i];
        a_trans = bus_io.htrans_m[i];
        a_write = bus_io.hwrite_m[i];
        a_size  = bus_io.hsize_m[i];
        a_burst = bus_io.hburst_m[i];
      end
      if (data_owner_q[i]) begin
        d_wdata = bus_io.hwdata_m[i];
      end
    end
  end

  // Address-phase outputs are blanked while reset is held, even if a grant is present.
  assign htrans_out = (hreset_n && !err_first) ? a_trans : 2'b00;
  assign hsel_out   = hreset_n & bus_io.hsel_arb & (|addr_sel);
  assign hburst_out = hreset_n ? a_burst : 3'b000;

  assign bus_io.haddr_s  = hreset_n ? a_addr : '0;
  assign bus_io.htrans_s = htrans_out;
  assign bus_io.hwrite_s = hreset_n & a_write;
  assign bus_io.hsize_s  = hreset_n ? a_size : 3'b000;
  assign bus_io.hburst_s = hburst_out;
  assign bus_io.hwdata_s = d_wdata;
  assign bus_io.hsel_s   = hsel_out;

  assign bus_io.hready_m = {N{bus_io.hreadyout_s}} & (data_owner_q | addr_sel);
  assign bus_io.hresp_m  = {N{bus_io.hresp_s}} & data_owner_q;
  assign bus_io.hrdata_m = bus_io.hrdata_s;
  assign bus_io.hwait    = ~bus_io.hreadyout_s;
  assign bus_io.hburst   = hburst_out;

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    if (bus_io.hreadyout_s) begin
      addr_owner_d = addr_sel;
      data_owner_d = (hsel_out && htrans_out[1]) ? addr_sel : '0;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
    end
  end
endmodule
